// File: rtl/t04_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package t04_muldiv_pkg;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  // Cycles from the edge that samples start to the cycle in which done is high
  localparam int MULDIV_LATENCY = 33;

endpackage

// File: rtl/t04_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, one radix-2
// step per cycle for XLEN cycles, then a single sign-fix cycle.
module t04_muldiv_unit
  import t04_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  // Magnitude of a value; the most negative signed value maps to its unsigned
  // magnitude, so no extra bit is needed.
  function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic is_signed);
    logic signed [XLEN-1:0] sv;
    sv = $signed(v);
    return (is_signed && (sv < 0)) ? -v : v;
  endfunction

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q, op_d;
  logic            neg_q, neg_d;        // negate product / quotient
  logic            rneg_q, rneg_d;      // remainder takes dividend sign
  logic [XLEN-1:0] hi_q, hi_d;          // product high word / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;          // multiplier -> product low / dividend -> quotient
  logic [XLEN-1:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            a_signed, b_signed, sa, sb;
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic; flush overrides everything including a same-cycle start
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CALC;
        CALC:    if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand latch, per-cycle shift-add / restoring-divide step, and sign fix
  always_comb begin
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    a_signed = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV) || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
               (funct3 == OP_DIV) || (funct3 == OP_REM);
    sa = a_signed & opA[XLEN-1];
    sb = b_signed & opB[XLEN-1];

    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : {XLEN{1'b0}})};
    div_diff = {1'b0, hi_q, lo_q[XLEN-1]} - {2'b00, mcand_q};

    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = rneg_q ? -hi_q : hi_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = muldiv_op_t'(funct3);
          hi_d   = '0;
          cnt_d  = '0;
          rneg_d = sa;
          if (funct3[2]) begin
            lo_d    = to_mag(opA, a_signed);
            mcand_d = to_mag(opB, b_signed);
            // Divide by zero keeps the all-ones quotient unsigned-looking
            neg_d   = (sa ^ sb) && (opB != '0);
          end else begin
            lo_d    = to_mag(opB, b_signed);
            mcand_d = to_mag(opA, a_signed);
            neg_d   = sa ^ sb;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q[2]) begin
          hi_d = div_diff[XLEN+1] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : div_diff[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
      FIX: begin
        if (!flush) begin
          case (op_q)
            OP_MUL:                  result_d = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                result_d = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:         result_d = quo_fix;
            default:                 result_d = rem_fix;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy   = (state_q == CALC) || (state_q == FIX);
    done   = (state_q == DONE);
    result = result_q;
  end

endmodule
